// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants and types used by the instruction-fetch stage.
package mips_pkg;

    // Encoding of "sll $0,$0,0"; used as the bubble instruction.
    localparam logic [31:0] NOP              = 32'h0000_0000;
    // Every instruction is one 32-bit word.
    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    // Default address the PC takes on reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    // Bubble value loaded into IF/ID on reset, flush or redirect.
    localparam ifid_t IFID_BUBBLE = '{instr: NOP, pc_plus4: 32'h0, valid: 1'b0};

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_stage_adder.sv
// Plain 32-bit adder; the carry-out is dropped so the sum wraps modulo 2^32.
module if_stage_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register. Define IF_PERF_CNT_EN to add fetch/bubble counters.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_target;
    logic        w_bubble;
    logic        w_capture;
    ifid_t       r_ifid;
    ifid_t       w_ifid_next;

    // The fetch address is the PC register itself, no extra latency.
    assign imem_addr         = r_pc;
    assign w_redirect_target = word_align(redirect_pc);

    // A taken branch kills the word being fetched this cycle, as does flush.
    assign w_bubble  = flush | redirect;
    assign w_capture = ~w_bubble & ~stall;

    if_stage_adder u_pc_adder (
        .i_a   (r_pc),
        .i_b   (INSTR_BYTES),
        .o_sum (w_pc_plus4)
    );

    // Next PC: redirect beats stall because the branch is the older instruction.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (redirect) begin
            w_pc_next = w_redirect_target;
        end else if (stall) begin
            w_pc_next = r_pc;
        end
    end

    // Next IF/ID: bubble on flush/redirect, hold on stall, else capture the fetch.
    always_comb begin
        w_ifid_next = r_ifid;
        if (w_bubble) begin
            w_ifid_next = IFID_BUBBLE;
        end else if (!stall) begin
            w_ifid_next.instr    = imem_rdata;
            w_ifid_next.pc_plus4 = w_pc_plus4;
            w_ifid_next.valid    = 1'b1;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= word_align(RESET_PC);
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid <= IFID_BUBBLE;
        end else begin
            r_ifid <= w_ifid_next;
        end
    end

    assign ifid_instr    = r_ifid.instr;
    assign ifid_pc_plus4 = r_ifid.pc_plus4;
    assign ifid_valid    = r_ifid.valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    // Count real captures and inserted bubbles; both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt  <= 32'h0;
            r_bubble_cnt <= 32'h0;
        end else begin
            if (w_capture) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_bubble) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = r_fetch_cnt;
    assign perf_bubble_cnt = r_bubble_cnt;
`else
    // Capture strobe only feeds the counters; keep it referenced otherwise.
    logic w_capture_unused;
    assign w_capture_unused = w_capture;
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port stall  input  1  hazard-unit hold of PC and IF/ID.
REQ-005 SHALL have port flush  input  1  turns the IF/ID register into a bubble.
REQ-006 SHALL have port redirect  input  1  taken branch/jump resolved downstream.
REQ-007 SHALL have port redirect_pc  input  32  branch/jump target.
REQ-008 SHALL have port imem_rdata  input  32  instruction word; combinational read of imem_addr.
REQ-009 SHALL have port imem_addr  output  32  current PC, driven to instruction memory.
REQ-010 SHALL have port ifid_instr  output  32  registered instruction to decode.
REQ-011 SHALL have port ifid_pc_plus4  output  32  registered PC+4 of ifid_instr.
REQ-012 SHALL have port ifid_valid  output  1  1 = ifid_instr is a real fetch, 0 = bubble.

Function
REQ-013 SHALL drive imem_addr directly from the PC register, with no added latency.
REQ-014 SHALL compute pc_plus4 = pc + 32'd4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000, no carry-out).
REQ-015 Next-PC priority SHALL be: redirect (PC <= {redirect_pc[31:2],2'b00}), then stall (PC holds), then sequential (PC <= pc_plus4).
REQ-016 redirect SHALL override stall in the same cycle, because the branch is older than the stalled instruction.
REQ-017 IF/ID priority SHALL be: flush or redirect loads a bubble (instr NOP, pc_plus4 0, valid 0), then stall holds all three, else captures imem_rdata, pc_plus4, and valid=1.
REQ-018 flush together with stall SHALL produce a bubble in IF/ID, while the PC still holds unless redirect is also high.
REQ-019 Fetch latency SHALL be one cycle: the word at PC p appears on ifid_instr at the edge after imem_addr = p.
REQ-020 PC bits [1:0] SHALL always be 0; low bits of redirect_pc SHALL be ignored.
REQ-021 Held state SHALL be unchanged across any number of consecutive stall cycles.

Reset
REQ-022 Asserting rst_n low SHALL immediately, with no clock edge, set PC=RESET_PC, ifid_instr=NOP, ifid_pc_plus4=0, ifid_valid=0, and any counters to 0.
REQ-023 Reset mid-operation SHALL discard any pending redirect or stall.
REQ-024 The first rising edge after deassertion SHALL fetch RESET_PC into IF/ID and advance PC to RESET_PC+4, provided stall, flush and redirect are low.

Configuration
REQ-025 With macro IF_PERF_CNT_EN defined, the block SHALL add outputs perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0].
REQ-026 perf_fetch_cnt SHALL increment on every cycle where IF/ID captures with valid=1.
REQ-027 perf_bubble_cnt SHALL increment on every cycle where flush or redirect inserts a bubble.
REQ-028 Both counters SHALL wrap modulo 2^32.
REQ-029 Without IF_PERF_CNT_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Shared package mips_pkg SHALL hold NOP (32'h0000_0000), INSTR_BYTES (4) and the default RESET_PC constant.
REQ-031 PC+4 SHALL be produced by one instance of the existing 32-bit adder module (inputs pc and INSTR_BYTES); no other sub-modules.
REQ-032 All state SHALL be in always blocks sensitive to posedge clk / negedge rst_n.

Verification
REQ-033 Reset release, all controls low, imem returning 32'h2008_0005 at 0x0 -> next edge: ifid_instr=32'h2008_0005, ifid_pc_plus4=0x4, ifid_valid=1, imem_addr=0x4.
REQ-034 Stall held 3 cycles at PC 0x10 -> imem_addr stays 0x10, IF/ID unchanged; after release, PC goes 0x10 -> 0x14.
REQ-035 redirect=1, redirect_pc=0x0000_0043, stall=1 in the same cycle -> PC=0x40, ifid_valid=0, ifid_instr=NOP.
REQ-036 flush=1 with stall=1 at PC 0x20 -> ifid_valid=0, PC stays 0x20.
REQ-037 PC forced to 0xFFFF_FFFC -> next PC 0x0, ifid_pc_plus4=0x0, ifid_valid=1.
REQ-038 With IF_PERF_CNT_EN defined: 5 fetches then 2 redirects -> perf_fetch_cnt=5, perf_bubble_cnt=2; rst_n pulsed low between clock edges -> both counters read 0 immediately.
